bj_game_ctrl: RTL and testbench

BJ_GAME_CTRL -- requirements
Module: bj_game_ctrl

---
 rtl/bj_game_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_bj_game_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bj_game_ctrl.sv
// Blackjack game controller: button conditioning, LFSR card source,
// per-hand running totals and the deal/player/dealer/result state machine.
module bj_game_ctrl #(
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          DEALER_STAND = 17
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       btn_deal,
   input  logic       btn_hit,
   input  logic       btn_stand,
   input  logic       dbg_card_en,
   input  logic [3:0] dbg_card,
   output logic [4:0] player_total,
   output logic [4:0] dealer_total,
   output logic [2:0] phase,
   output logic [1:0] result,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DEAL   = 3'd1,
      S_PLAYER = 3'd2,
      S_DEALER = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   localparam logic [4:0] STAND_TOTAL = 5'(DEALER_STAND);

   // Button index within the conditioning vectors.
   localparam int B_DEAL  = 0;
   localparam int B_HIT   = 1;
   localparam int B_STAND = 2;

   logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [1:0]  settle_q, settle_d;
   logic [15:0] lfsr_q, lfsr_d;
   state_t      state_q, state_d;
   logic [4:0]  p_hard_q, p_hard_d, d_hard_q, d_hard_d;
   logic        p_ace_q, p_ace_d, d_ace_q, d_ace_d;
   logic [1:0]  card_cnt_q, card_cnt_d;
   logic        hit_pend_q, hit_pend_d;
   logic [1:0]  result_q, result_d;
   logic        busy_q, busy_d;

   logic        settled;
   logic [2:0]  pulse;
   logic        card_valid;
   logic [3:0]  card_rank;
   logic [4:0]  card_val;
   logic        card_ace;
   logic [4:0]  p_best, d_best;

   function automatic logic [4:0] add_sat(input logic [4:0] hard, input logic [4:0] val);
      logic [5:0] sum;
      sum = {1'b0, hard} + {1'b0, val};
      return sum[5] ? 5'd31 : sum[4:0];
   endfunction

   // An ace counts as 11 only while that keeps the hand at 21 or below.
   function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
      if (ace && hard <= 5'd11) return hard + 5'd10;
      return hard;
   endfunction

   assign p_best = best_total(p_hard_q, p_ace_q);
   assign d_best = best_total(d_hard_q, d_ace_q);

   // Button synchronizers and edge detectors. The edge detector is held high
   // until the synchronizer pipeline has refilled after reset, so a button
   // held through reset release never looks like a fresh press.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and sequential blocks use
      // non-blocking '<=', so simulation ordering matches the synthesized logic.
      sync1_d  = {btn_stand, btn_hit, btn_deal};
      sync2_d  = sync1_q;
      settled  = (settle_q == 2'd2);
      settle_d = settled ? settle_q : settle_q + 2'd1;
      prev_d   = settled ? sync2_q : 3'b111;
      pulse    = settled ? (sync2_q & ~prev_q) : 3'b000;
   end

   // Card source: LFSR advance plus rank/value decode of this cycle's draw.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (dbg_card_en) begin
         card_valid = 1'b1;
         card_rank  = (dbg_card == 4'd0 || dbg_card > 4'd13) ? 4'd1 : dbg_card;
      end else begin
         card_valid = (lfsr_q[3:0] <= 4'd12);
         card_rank  = lfsr_q[3:0] + 4'd1;
      end
      card_ace = (card_rank == 4'd1);
      card_val = (card_rank >= 4'd10) ? 5'd10 : {1'b0, card_rank};
   end

   // Game state machine next-state and hand bookkeeping.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      p_hard_d   = p_hard_q;
      d_hard_d   = d_hard_q;
      p_ace_d    = p_ace_q;
      d_ace_d    = d_ace_q;
      card_cnt_d = card_cnt_q;
      hit_pend_d = hit_pend_q;
      result_d   = result_q;

      case (state_q)
         S_IDLE, S_RESULT: begin
            if (pulse[B_DEAL]) begin
               state_d    = S_DEAL;
               p_hard_d   = 5'd0;
               d_hard_d   = 5'd0;
               p_ace_d    = 1'b0;
               d_ace_d    = 1'b0;
               card_cnt_d = 2'd0;
               hit_pend_d = 1'b0;
               result_d   = 2'b00;
            end
         end
         S_DEAL: begin
            if (card_valid) begin
               // Even-numbered cards go to the player, odd ones to the dealer.
               if (!card_cnt_q[0]) begin
                  p_hard_d = add_sat(p_hard_q, card_val);
                  p_ace_d  = p_ace_q | card_ace;
               end else begin
                  d_hard_d = add_sat(d_hard_q, card_val);
                  d_ace_d  = d_ace_q | card_ace;
               end
               card_cnt_d = card_cnt_q + 2'd1;
               if (card_cnt_q == 2'd3) state_d = S_PLAYER;
            end
         end
         S_PLAYER: begin
            if (p_hard_q > 5'd21) begin
               state_d    = S_RESULT;
               result_d   = 2'b10;
               hit_pend_d = 1'b0;
            end else if (p_best == 5'd21 || pulse[B_STAND]) begin
               // Stand takes priority; a simultaneous hit is simply dropped.
               state_d    = S_DEALER;
               hit_pend_d = 1'b0;
            end else if (hit_pend_q && card_valid) begin
               p_hard_d   = add_sat(p_hard_q, card_val);
               p_ace_d    = p_ace_q | card_ace;
               hit_pend_d = 1'b0;
            end else if (pulse[B_HIT]) begin
               hit_pend_d = 1'b1;
            end
         end
         S_DEALER: begin
            if (d_best < STAND_TOTAL) begin
               if (card_valid) begin
                  d_hard_d = add_sat(d_hard_q, card_val);
                  d_ace_d  = d_ace_q | card_ace;
               end
            end else begin
               state_d = S_RESULT;
               if (d_hard_q > 5'd21)     result_d = 2'b01;
               else if (p_best > d_best) result_d = 2'b01;
               else if (p_best < d_best) result_d = 2'b10;
               else                      result_d = 2'b11;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_DEAL) || (state_d == S_DEALER);
   end

   // State registers; everything holds while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 3'b000;
         sync2_q    <= 3'b000;
         prev_q     <= 3'b111;
         settle_q   <= 2'd0;
         lfsr_q     <= LFSR_SEED;
         state_q    <= S_IDLE;
         p_hard_q   <= 5'd0;
         d_hard_q   <= 5'd0;
         p_ace_q    <= 1'b0;
         d_ace_q    <= 1'b0;
         card_cnt_q <= 2'd0;
         hit_pend_q <= 1'b0;
         result_q   <= 2'b00;
         busy_q     <= 1'b0;
      end else if (ena) begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         settle_q   <= settle_d;
         lfsr_q     <= lfsr_d;
         state_q    <= state_d;
         p_hard_q   <= p_hard_d;
         d_hard_q   <= d_hard_d;
         p_ace_q    <= p_ace_d;
         d_ace_q    <= d_ace_d;
         card_cnt_q <= card_cnt_d;
         hit_pend_q <= hit_pend_d;
         result_q   <= result_d;
         busy_q     <= busy_d;
      end
   end

   assign player_total = p_best;
   assign dealer_total = d_best;
   assign phase        = state_q;
   assign result       = result_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_bj_game_ctrl.sv
// Directed bench for bj_game_ctrl: scripted hands with forced cards, reset
// behaviour, then a long run of LFSR-dealt hands with random buttons.
module tb_bj_game_ctrl;

   localparam logic [2:0] P_IDLE   = 3'd0;
   localparam logic [2:0] P_DEAL   = 3'd1;
   localparam logic [2:0] P_PLAYER = 3'd2;
   localparam logic [2:0] P_DEALER = 3'd3;
   localparam logic [2:0] P_RESULT = 3'd4;
   localparam logic [15:0] SEED    = 16'hACE1;

   logic       clk, rst_n, ena;
   logic       btn_deal, btn_hit, btn_stand;
   logic       dbg_card_en;
   logic [3:0] dbg_card;
   logic [4:0] player_total, dealer_total;
   logic [2:0] phase;
   logic [1:0] result;
   logic       busy;

   int         n_checks = 0;
   int         n_errors = 0;
   logic       mon_en   = 1'b0;
   logic [15:0] lfsr_m;

   bj_game_ctrl #(.LFSR_SEED(SEED), .DEALER_STAND(17)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .btn_deal     (btn_deal),
      .btn_hit      (btn_hit),
      .btn_stand    (btn_stand),
      .dbg_card_en  (dbg_card_en),
      .dbg_card     (dbg_card),
      .player_total (player_total),
      .dealer_total (dealer_total),
      .phase        (phase),
      .result       (result),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)   lfsr_m <= SEED;
      else if (ena) lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Wait (bounded) at negedges until phase reaches target.
   task automatic wait_phase(input logic [2:0] target, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         if (phase == target) break;
         @(negedge clk);
      end
      check(tag, 32'(phase), 32'(target));
   endtask

   // Press one button (0 deal, 1 hit, 2 stand) long enough to act, then release.
   task automatic pulse_btn(input int which);
      if (which == 0) btn_deal = 1'b1;
      else if (which == 1) btn_hit = 1'b1;
      else btn_stand = 1'b1;
      repeat (4) @(negedge clk);
      btn_deal = 1'b0; btn_hit = 1'b0; btn_stand = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Start a hand with four forced cards; returns at the negedge where the
   // dealing has just finished.
   task automatic deal_cards(input logic [3:0] c0, input logic [3:0] c1,
                             input logic [3:0] c2, input logic [3:0] c3);
      dbg_card = c0;
      btn_deal = 1'b1;
      wait_phase(P_DEAL, 10, "enter_deal");
      @(negedge clk) dbg_card = c1;
      @(negedge clk) dbg_card = c2;
      @(negedge clk) dbg_card = c3;
      @(negedge clk);
      btn_deal = 1'b0;
      check("deal_done", 32'(phase), 32'(P_PLAYER));
   endtask

   // Phase must always be a legal encoding during the random run.
   always @(negedge clk) begin
      if (mon_en) check("phase_range", 32'(phase <= P_RESULT), 32'd1);
   end

   initial begin
      rst_n = 1'b1; ena = 1'b1;
      btn_deal = 1'b0; btn_hit = 1'b0; btn_stand = 1'b0;
      dbg_card_en = 1'b1; dbg_card = 4'd1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_phase",  32'(phase), 32'(P_IDLE));
      check("rst_player", 32'(player_total), 32'd0);
      check("rst_dealer", 32'(dealer_total), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_lfsr",   32'(dut.lfsr_q), 32'(SEED));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Deal: 10,9,A,7 -> player soft 21 moves on without a button;
      // dealer 16 draws a 5 -> 21, push.
      deal_cards(4'd10, 4'd9, 4'd1, 4'd7);
      check("t1_player", 32'(player_total), 32'd21);
      check("t1_dealer16", 32'(dealer_total), 32'd16);
      dbg_card = 4'd5;
      pulse_btn(2);
      wait_phase(P_RESULT, 20, "t1_result_phase");
      check("t1_player_end", 32'(player_total), 32'd21);
      check("t1_dealer_end", 32'(dealer_total), 32'd21);
      check("t1_result", 32'(result), 32'b11);
      check("t1_busy", 32'(busy), 32'd0);

      // Bust: 10,6,5,8 then hit a 9 -> player 24, lose, dealer stays 14.
      deal_cards(4'd10, 4'd6, 4'd5, 4'd8);
      check("t2_player15", 32'(player_total), 32'd15);
      dbg_card = 4'd9;
      pulse_btn(1);
      wait_phase(P_RESULT, 20, "t2_result_phase");
      check("t2_player", 32'(player_total), 32'd24);
      check("t2_dealer", 32'(dealer_total), 32'd14);
      check("t2_result", 32'(result), 32'b10);

      // Soft ace (forced code 0 counts as an ace): A,6 = 17, hit 10 -> hard 17.
      deal_cards(4'd0, 4'd5, 4'd6, 4'd5);
      check("t3_soft17", 32'(player_total), 32'd17);
      dbg_card = 4'd10;
      pulse_btn(1);
      check("t3_phase", 32'(phase), 32'(P_PLAYER));
      check("t3_hard17", 32'(player_total), 32'd17);
      pulse_btn(2);
      wait_phase(P_RESULT, 20, "t3_result_phase");
      check("t3_dealer", 32'(dealer_total), 32'd20);
      check("t3_result", 32'(result), 32'b10);

      // Hit and stand together: stand wins, no card. Queen counts 10.
      deal_cards(4'd12, 4'd2, 4'd3, 4'd4);
      check("t4_player13", 32'(player_total), 32'd13);
      dbg_card = 4'd13;
      btn_hit = 1'b1; btn_stand = 1'b1;
      wait_phase(P_DEALER, 10, "t4_dealer_phase");
      check("t4_player_same", 32'(player_total), 32'd13);
      btn_hit = 1'b0; btn_stand = 1'b0;
      wait_phase(P_RESULT, 20, "t4_result_phase");
      check("t4_dealer_bust", 32'(dealer_total), 32'd26);
      check("t4_result", 32'(result), 32'b01);

      // ena low freezes the dealer mid-turn; reset then aborts the hand.
      deal_cards(4'd2, 4'd2, 4'd3, 4'd2);
      dbg_card = 4'd1;
      btn_stand = 1'b1;
      wait_phase(P_DEALER, 10, "t5_dealer_phase");
      ena = 1'b0;
      check("t5_busy", 32'(busy), 32'd1);
      check("t5_dealer4", 32'(dealer_total), 32'd4);
      repeat (5) @(negedge clk);
      check("t5_frozen_phase", 32'(phase), 32'(P_DEALER));
      check("t5_frozen_dealer", 32'(dealer_total), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_phase",  32'(phase), 32'(P_IDLE));
      check("t5_rst_player", 32'(player_total), 32'd0);
      check("t5_rst_dealer", 32'(dealer_total), 32'd0);
      check("t5_rst_result", 32'(result), 32'd0);
      check("t5_rst_busy",   32'(busy), 32'd0);
      btn_stand = 1'b0;
      btn_deal  = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;
      repeat (10) @(negedge clk);
      check("t5_held_deal_idle", 32'(phase), 32'(P_IDLE));
      btn_deal = 1'b0;
      repeat (3) @(negedge clk);

      // Fresh press works; 10+A = 21 auto-stands, dealer 10+7 = 17 stops.
      deal_cards(4'd10, 4'd10, 4'd1, 4'd7);
      dbg_card = 4'd2;
      wait_phase(P_RESULT, 20, "t6_result_phase");
      check("t6_dealer17", 32'(dealer_total), 32'd17);
      check("t6_result", 32'(result), 32'b01);

      // LFSR-dealt hands with random hit/stand presses.
      dbg_card_en = 1'b0;
      mon_en = 1'b1;
      for (int h = 0; h < 1000; h++) begin
         pulse_btn(0);
         check("rand_dealing", 32'(phase), 32'(P_DEAL));
         for (int k = 0; k < 100; k++) begin
            if (phase != P_DEAL) break;
            @(negedge clk);
         end
         for (int k = 0; k < 6; k++) begin
            if (phase != P_PLAYER) break;
            pulse_btn(int'($urandom_range(1, 2)));
         end
         if (phase == P_PLAYER) pulse_btn(2);
         wait_phase(P_RESULT, 400, "rand_result_phase");
         check("rand_result_set", 32'(result != 2'b00), 32'd1);
         check("rand_lfsr_model", 32'(dut.lfsr_q), 32'(lfsr_m));
         check("rand_lfsr_nonzero", 32'(dut.lfsr_q != 16'd0), 32'd1);
      end
      mon_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
